// File: rtl/odd_parity_rx.sv
// odd_parity_rx
//   Serial receiver for an 8-bit odd-parity link. A frame is 1 start bit,
//   8 data bits (LSB first), 1 odd-parity bit and 1 stop bit. Each bit is
//   sampled near its centre, timed from the synchronised start edge.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_serial   serial line, idles high, asynchronous to clk
//   data_out    last received byte, held until the next frame completes
//   data_valid  one-cycle strobe qualifying data_out / parity_err / frame_err
//   parity_err  data bits plus parity bit hold an even number of ones
//   frame_err   sampled stop bit was 0
//   busy        high while a frame is in progress
module odd_parity_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    idx;
  logic          s1, s2, s_prev;
  logic          start_det;
  logic [7:0]    shreg;
  logic          par_bit;

  // Odd parity: a correct frame has an odd count of ones over data + parity.
  function automatic logic parity_fault(input logic [7:0] b, input logic p);
    return ~(^{b, p});
  endfunction

  // Arm only on a genuine falling edge so a held-low (break) line cannot
  // retrigger the receiver after a frame.
  assign start_det = s_prev & ~s2;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      s_prev     <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      s1         <= rx_serial;
      s2         <= s1;
      s_prev     <= s2;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == HALF_CNT) begin
            if (!s2) begin
              bit_cnt <= '0;
              idx     <= '0;
              state   <= DATA;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == FULL_CNT) begin
            bit_cnt <= '0;
            if (idx == 3'd7) state <= PARITY;
            else             idx   <= idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_cnt == FULL_CNT) begin
            bit_cnt <= '0;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == FULL_CNT) begin
            bit_cnt    <= '0;
            data_out   <= shreg;
            parity_err <= parity_fault(shreg, par_bit);
            frame_err  <= ~s2;
            data_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath capture: no reset needed, contents are only consumed after a
  // full frame has overwritten them.
  always_ff @(posedge clk) begin
    if (state == DATA && bit_cnt == FULL_CNT)
      shreg <= {s2, shreg[7:1]};
    if (state == PARITY && bit_cnt == FULL_CNT)
      par_bit <= s2;
  end

endmodule

// File: tb/tb_odd_parity_rx.sv
// tb_odd_parity_rx
//   Bench for odd_parity_rx: directed vector table, hand-written multi-cycle
//   sequences (glitch, reset mid-frame) and random frames, checked against a
//   behavioural frame model through an expected-result queue.
module tb_odd_parity_rx;

  localparam int C = 16;
  // Cycle count from the falling start edge (driven on a negedge) to the
  // negedge where the strobe is seen: 3 synchroniser/detect edges, half a
  // bit to the start sample, ten bit times to the stop sample.
  localparam int LAT = 3 + C / 2 + 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  odd_parity_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial),
    .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ed;
    logic       ep;
    logic       ef;
    int         fall_cyc;
    bit         lat;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         low_bits;   // extra bit times the line stays low after the frame
    int         gap_bits;   // idle-high bit times after that
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] last_d = 8'h00;
  logic       last_p = 1'b0;
  logic       last_f = 1'b0;
  bit         prev_dv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: odd parity over data + parity bit, stop must be 1.
  function automatic exp_t model(input logic [7:0] d, input logic p, input logic s);
    exp_t e;
    int ones;
    ones = p ? 1 : 0;
    for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
    e.ed = d;
    e.ep = (ones % 2 == 0);
    e.ef = !s;
    e.fall_cyc = 0;
    e.lat = 0;
    return e;
  endfunction

  // Drives the first nbits of a frame, one bit per C cycles, from a negedge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input bit push, input bit lat);
    logic [10:0] fr;
    exp_t e;
    fr = {s, p, d, 1'b0};
    if (push) begin
      e = model(d, p, s);
      e.fall_cyc = cyc;
      e.lat = lat;
      exp_q.push_back(e);
      last_d = e.ed; last_p = e.ep; last_f = e.ef;
    end
    for (int i = 0; i < nbits; i++) begin
      rx_serial = fr[i];
      if (i == 0 && lat) begin
        repeat (2) @(negedge clk);
        chk("busy_before_detect", busy, 1'b0);
        @(negedge clk);
        chk("busy_after_detect", busy, 1'b1);
        repeat (C - 3) @(negedge clk);
      end else begin
        repeat (C) @(negedge clk);
      end
    end
  endtask

  // Strobe monitor: every strobe must match the next expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_dv = 1'b0;
    end else begin
      if (data_valid) begin
        chk("dv_not_double", prev_dv, 1'b0);
        chk("busy_low_on_strobe", busy, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", data_out, e.ed);
          chk("parity_err", parity_err, e.ep);
          chk("frame_err", frame_err, e.ef);
          if (e.lat) chk("strobe_latency", cyc - e.fall_cyc, LAT);
        end
      end
      prev_dv = data_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0,  0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 0,  1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 40, 2, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 0,  0, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 0,  1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 0,  0, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h7F, 1'b1, 1'b1, 0,  0, 8'h7F, 1'b1, 1'b0};
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 0,  1, 8'hC3, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_flags", {parity_err, frame_err}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed vector table; frames run back-to-back unless a gap is given.
    for (int v = 0; v < 8; v++) begin
      exp_t m;
      m = model(vecs[v].d, vecs[v].p, vecs[v].s);
      chk("table_model_agrees", {m.ed, m.ep, m.ef}, {vecs[v].ed, vecs[v].ep, vecs[v].ef});
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s, 11, 1'b1, v == 0);
      rx_serial = vecs[v].s;
      if (vecs[v].low_bits > 0) begin
        rx_serial = 1'b0;
        repeat (vecs[v].low_bits * C) @(negedge clk);
        chk("no_strobe_during_break", exp_q.size(), 0);
      end
      rx_serial = 1'b1;
      repeat (vecs[v].gap_bits * C) @(negedge clk);
    end
    repeat (2 * C) @(negedge clk);
    chk("table_all_delivered", exp_q.size(), 0);

    // Start glitch: 5 clocks low must be rejected at the mid-start sample.
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_high", busy, 1'b1);
    rx_serial = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_hold_data", data_out, last_d);
    chk("glitch_hold_flags", {parity_err, frame_err}, {last_p, last_f});

    // Reset during data bit 4, then a fresh frame.
    send_frame(8'hAA, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_outputs", {data_valid, parity_err, frame_err, busy}, 4'b0000);
    rst_n = 1'b1;
    last_d = 8'h00; last_p = 1'b0; last_f = 1'b0;
    repeat (C) @(negedge clk);
    chk("post_rst_idle", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1, 1'b1);
    rx_serial = 1'b1;
    repeat (2 * C) @(negedge clk);
    chk("post_rst_delivered", exp_q.size(), 0);

    // Random frames against the model.
    for (int r = 0; r < 16; r++) begin
      logic [7:0] d;
      logic p, s;
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 11, 1'b1, 1'b1);
      rx_serial = 1'b1;
      if (!s) repeat (C) @(negedge clk);
      repeat ($urandom_range(0, 2 * C)) @(negedge clk);
    end
    repeat (2 * C) @(negedge clk);
    chk("random_all_delivered", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
